scoreboard_hazard_unit: RTL and testbench

- Producer-side hazard controller for the 5-stage RV32IM pipeline. Forwarding covers single-cycle producers; this block covers hazards forwarding cannot hide.
- Load-use hazards: detected combinationally, resolved with a 1-cycle stall.
- Multi-cycle divider results: tracked in a 32-entry pending-write scoreboard, set at issue and cleared at writeback.
- Drives the PC/IF-ID hold and the ID/EX bubble, with a divider watchdog and a stall performance counter.

---
 rtl/scoreboard_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: producer-side hazard controller for the 5-stage
// RV32IM pipeline. It stalls on load-use hazards and on hazards against an
// outstanding multi-cycle divide, which is tracked in a pending-write
// scoreboard. It also provides a divider watchdog and a saturating stall counter.
module scoreboard_hazard_unit #(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             if_id_rs1_addr_i,
    input  logic [4:0]             if_id_rs2_addr_i,
    input  logic                   if_id_rs1_used_i,
    input  logic                   if_id_rs2_used_i,
    input  logic [4:0]             if_id_rd_addr_i,
    input  logic                   if_id_reg_write_i,
    input  logic                   if_id_is_div_i,
    input  logic                   id_ex_mem_read_i,
    input  logic [4:0]             id_ex_rd_addr_i,
    input  logic                   div_start_i,
    input  logic [4:0]             div_rd_addr_i,
    input  logic                   div_done_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   bubble_o,
    output logic                   div_busy_o,
    output logic [4:0]             pending_rd_o,
    output logic                   timeout_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [31:0]            pending_q;
    logic [4:0]             pending_rd_q;
    logic [15:0]            wd_cnt_q;
    logic                   timeout_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic [31:0] set_mask;
    logic [31:0] done_mask;
    logic [31:0] eff_pending;
    logic        load_use;
    logic        raw_div;
    logic        waw_div;
    logic        struct_div;
    logic        stall;

    // Scoreboard masks and the four hazard terms; all combinational
    always_comb begin
        set_mask    = '0;
        done_mask   = '0;
        eff_pending = '0;
        load_use    = 1'b0;
        raw_div     = 1'b0;
        waw_div     = 1'b0;
        struct_div  = 1'b0;
        stall       = 1'b0;

        // x0 is never marked pending
        if (div_rd_addr_i != 5'd0) begin
            set_mask = 32'd1 << div_rd_addr_i;
        end
        // A completing divide reaches ID through the writeback path, so its
        // bit no longer blocks readers in the done cycle
        if ((state_q == BUSY) && div_done_i) begin
            done_mask = 32'd1 << pending_rd_q;
        end
        eff_pending = pending_q & ~done_mask;

        load_use = id_ex_mem_read_i && (id_ex_rd_addr_i != 5'd0) &&
                   (((if_id_rs1_addr_i == id_ex_rd_addr_i) && if_id_rs1_used_i) ||
                    ((if_id_rs2_addr_i == id_ex_rd_addr_i) && if_id_rs2_used_i));
        raw_div  = (eff_pending[if_id_rs1_addr_i] && if_id_rs1_used_i) ||
                   (eff_pending[if_id_rs2_addr_i] && if_id_rs2_used_i);
        waw_div  = if_id_reg_write_i && (if_id_rd_addr_i != 5'd0) &&
                   eff_pending[if_id_rd_addr_i];
        struct_div = if_id_is_div_i && (state_q == BUSY) && !div_done_i;

        stall = !flush_i && (load_use || raw_div || waw_div || struct_div);
    end

    // Divider tracking FSM: scoreboard, tracked rd, watchdog and sticky timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            pending_rd_q <= '0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start_i) begin
                        state_q      <= BUSY;
                        pending_q    <= pending_q | set_mask;
                        pending_rd_q <= div_rd_addr_i;
                        wd_cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (div_done_i) begin
                        // Back-to-back issue: clear the old entry and set the new
                        // one in the same cycle; same rd leaves the bit set
                        pending_q <= (pending_q & ~done_mask) |
                                     (div_start_i ? set_mask : '0);
                        wd_cnt_q  <= '0;
                        if (div_start_i) begin
                            pending_rd_q <= div_rd_addr_i;
                        end else begin
                            state_q      <= IDLE;
                            pending_rd_q <= '0;
                        end
                    end else if (wd_cnt_q == 16'(DIV_TIMEOUT - 1)) begin
                        state_q      <= IDLE;
                        pending_q    <= '0;
                        pending_rd_q <= '0;
                        wd_cnt_q     <= '0;
                        timeout_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Next value of the saturating stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Stall performance counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o       = stall;
    assign bubble_o      = stall;
    assign div_busy_o    = (state_q == BUSY);
    assign pending_rd_o  = pending_rd_q;
    assign timeout_o     = timeout_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit. A second instance with a short
// watchdog shares all inputs and is checked only in the timeout section.
module tb_scoreboard_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, id_rd, ex_rd, div_rd;
    logic        rs1_used, rs2_used, reg_write, is_div, mem_read;
    logic        div_start, div_done, flush;

    logic        stall, bubble, busy, timeout;
    logic [4:0]  pend_rd;
    logic [15:0] scount;

    logic        wd_stall, wd_bubble, wd_busy, wd_timeout;
    logic [4:0]  wd_pend_rd;
    logic [15:0] wd_scount;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    scoreboard_hazard_unit #(.DIV_TIMEOUT(64), .STALL_CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr_i(rs1), .if_id_rs2_addr_i(rs2),
        .if_id_rs1_used_i(rs1_used), .if_id_rs2_used_i(rs2_used),
        .if_id_rd_addr_i(id_rd), .if_id_reg_write_i(reg_write),
        .if_id_is_div_i(is_div), .id_ex_mem_read_i(mem_read),
        .id_ex_rd_addr_i(ex_rd), .div_start_i(div_start),
        .div_rd_addr_i(div_rd), .div_done_i(div_done), .flush_i(flush),
        .stall_o(stall), .bubble_o(bubble), .div_busy_o(busy),
        .pending_rd_o(pend_rd), .timeout_o(timeout), .stall_count_o(scount)
    );

    scoreboard_hazard_unit #(.DIV_TIMEOUT(8), .STALL_CNT_W(16)) u_wd (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr_i(rs1), .if_id_rs2_addr_i(rs2),
        .if_id_rs1_used_i(rs1_used), .if_id_rs2_used_i(rs2_used),
        .if_id_rd_addr_i(id_rd), .if_id_reg_write_i(reg_write),
        .if_id_is_div_i(is_div), .id_ex_mem_read_i(mem_read),
        .id_ex_rd_addr_i(ex_rd), .div_start_i(div_start),
        .div_rd_addr_i(div_rd), .div_done_i(div_done), .flush_i(flush),
        .stall_o(wd_stall), .bubble_o(wd_bubble), .div_busy_o(wd_busy),
        .pending_rd_o(wd_pend_rd), .timeout_o(wd_timeout), .stall_count_o(wd_scount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1 = '0; rs2 = '0; id_rd = '0; ex_rd = '0; div_rd = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; reg_write = 1'b0; is_div = 1'b0;
        mem_read = 1'b0; div_start = 1'b0; div_done = 1'b0; flush = 1'b0;
    endtask

    // Advance to the next falling edge and start from quiet inputs
    task automatic nxt();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend_rd", pend_rd, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_count", scount, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- load-use ----
        nxt(); mem_read = 1; ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1; #1;
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        nxt(); rs1 = 5'd5; rs1_used = 1; #1;
        chk("lu_release", stall, 0);
        chk("lu_count", scount, 1);
        nxt(); mem_read = 1; ex_rd = 5'd0; rs1 = 5'd0; rs1_used = 1; #1;
        chk("lu_x0", stall, 0);
        nxt(); mem_read = 1; ex_rd = 5'd5; rs2 = 5'd5; rs2_used = 0; #1;
        chk("lu_rs2_unused", stall, 0);
        nxt(); mem_read = 1; ex_rd = 5'd5; rs2 = 5'd5; rs2_used = 1; #1;
        chk("lu_rs2", stall, 1);
        nxt(); #1;
        chk("lu_count2", scount, 2);

        // ---- divide RAW, done 10 cycles after start ----
        nxt(); div_start = 1; div_rd = 5'd7; #1;
        chk("raw_issue_stall", stall, 0);
        for (int i = 1; i <= 9; i++) begin
            nxt(); rs1 = 5'd7; rs1_used = 1; #1;
            chk("raw_stall", stall, 1);
            chk("raw_busy", busy, 1);
            chk("raw_pend_rd", pend_rd, 7);
        end
        nxt(); rs1 = 5'd7; rs1_used = 1; div_done = 1; #1;
        chk("raw_done_stall", stall, 0);
        chk("raw_done_busy", busy, 1);
        nxt(); rs1 = 5'd7; rs1_used = 1; #1;
        chk("raw_after_busy", busy, 0);
        chk("raw_after_pend", pend_rd, 0);
        chk("raw_after_stall", stall, 0);
        chk("raw_count", scount, 11);

        // ---- WAW, structural, unrelated reader ----
        nxt(); div_start = 1; div_rd = 5'd7; #1;
        nxt(); reg_write = 1; id_rd = 5'd7; #1;
        chk("waw_stall", stall, 1);
        nxt(); is_div = 1; #1;
        chk("struct_stall", stall, 1);
        nxt(); rs1 = 5'd8; rs1_used = 1; #1;
        chk("x8_nostall", stall, 0);
        nxt(); reg_write = 1; id_rd = 5'd7; is_div = 1; div_done = 1; #1;
        chk("waw_done_stall", stall, 0);
        nxt(); #1;
        chk("waw_after_busy", busy, 0);
        chk("waw_count", scount, 13);

        // ---- same-cycle done (x3) and start (x4) ----
        nxt(); div_start = 1; div_rd = 5'd3; #1;
        nxt(); div_done = 1; div_start = 1; div_rd = 5'd4; rs1 = 5'd3; rs1_used = 1; #1;
        chk("bb_x3_done_cycle", stall, 0);
        nxt(); rs1 = 5'd3; rs1_used = 1; #1;
        chk("bb_busy", busy, 1);
        chk("bb_pend_rd", pend_rd, 4);
        chk("bb_x3_reader", stall, 0);
        nxt(); rs2 = 5'd4; rs2_used = 1; #1;
        chk("bb_x4_reader", stall, 1);
        nxt(); rs2 = 5'd4; rs2_used = 1; div_done = 1; #1;
        chk("bb_x4_done", stall, 0);
        nxt(); #1;
        chk("bb_idle", busy, 0);
        chk("bb_count", scount, 14);

        // ---- flush priority ----
        nxt(); flush = 1; mem_read = 1; ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1; #1;
        chk("flush_stall", stall, 0);
        chk("flush_bubble", bubble, 0);
        nxt(); #1;
        chk("flush_count", scount, 14);

        // ---- watchdog (short-timeout instance) and async reset ----
        nxt(); rst = 1'b1; #1;
        nxt(); rst = 1'b0;
        nxt(); div_start = 1; div_rd = 5'd9; #1;
        for (int k = 1; k <= 8; k++) begin
            nxt(); rs1 = 5'd9; rs1_used = 1; #1;
            chk("wd_stall", wd_stall, 1);
            chk("wd_busy", wd_busy, 1);
            chk("wd_not_yet", wd_timeout, 0);
        end
        nxt(); rs1 = 5'd9; rs1_used = 1; #1;
        chk("wd_fired", wd_timeout, 1);
        chk("wd_idle", wd_busy, 0);
        chk("wd_released", wd_stall, 0);
        chk("wd_pend_rd", wd_pend_rd, 0);
        chk("main_still_stall", stall, 1);
        nxt(); rs1 = 5'd9; rs1_used = 1; #1;
        chk("wd_sticky", wd_timeout, 1);
        chk("main_busy", busy, 1);
        chk("main_pend_rd", pend_rd, 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pend_rd", pend_rd, 0);
        chk("arst_stall", stall, 0);
        chk("arst_count", scount, 0);
        chk("arst_wd_timeout", wd_timeout, 0);
        nxt(); rst = 1'b0;

        // ---- stall counter saturation ----
        nxt(); mem_read = 1; ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1; #1;
        chk("sat_start", scount, 0);
        repeat (1000) @(negedge clk);
        #1;
        chk("sat_1000", scount, 1000);
        repeat (65000) @(negedge clk);
        #1;
        chk("sat_hold", scount, 16'hFFFF);
        chk("sat_stall", stall, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
